gpio_irq: RTL

GPIO_IRQ -- requirements
Module: gpio_irq

---
 rtl/bus_if_types_pkg.sv | 22 ++
 rtl/slave_bus_if.sv | 16 +
 rtl/gpio_debounce.sv | 50 +++++
 rtl/gpio_irq.sv | 90 +++++++++
 4 files changed

// File: rtl/bus_if_types_pkg.sv
// Shared slave-bus types and the gpio_irq register offsets.
// Bus agents and register blocks import this package.
package bus_if_types_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } ttype_e;

    localparam logic [7:0] GPIO_IRQ_PIN_VAL = 8'h00;
    localparam logic [7:0] GPIO_IRQ_RISE_EN = 8'h04;
    localparam logic [7:0] GPIO_IRQ_FALL_EN = 8'h08;
    localparam logic [7:0] GPIO_IRQ_PENDING = 8'h0C;
    localparam logic [7:0] GPIO_IRQ_IRQ_EN  = 8'h10;
    localparam logic [7:0] GPIO_IRQ_DIV     = 8'h14;

    localparam logic [7:0] GPIO_IRQ_DIV_RST = 8'hFF;

endpackage

// File: rtl/slave_bus_if.sv
// Simple single-cycle register bus: the slave always completes in the
// same cycle, so rdata is combinational from addr.
interface slave_bus_if;
    import bus_if_types_pkg::*;

    logic                  ss;
    ttype_e                ttype;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
    logic [BUS_DATA_W-1:0] rdata;
    logic                  bdone;

    modport master (output ss, ttype, addr, wdata, input rdata, bdone);
    modport slave  (input ss, ttype, addr, wdata, output rdata, bdone);

endinterface

// File: rtl/gpio_debounce.sv
// One GPIO pin: two-flop synchronizer, tick-based stability counter,
// debounced value and single-cycle rise/fall flags.
module gpio_debounce #(
    parameter int DB_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_in,
    input  logic tick,
    output logic pin_val,
    output logic rise,
    output logic fall
);

    localparam int CW = (DB_TICKS < 2) ? 1 : $clog2(DB_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(DB_TICKS - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            pin_val <= 1'b0;
            cnt     <= '0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync1 <= pin_in;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            // Any agreement with the accepted value throws away progress.
            if (sync2 == pin_val) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == LAST) begin
                    pin_val <= sync2;
                    cnt     <= '0;
                    rise    <= sync2;
                    fall    <= ~sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gpio_irq.sv
// GPIO input conditioner with edge-triggered, maskable level interrupt.
// Prescaler and register file live here; per-pin logic is in gpio_debounce.
module gpio_irq
    import bus_if_types_pkg::*;
#(
    parameter int NPIN     = 8,
    parameter int DB_TICKS = 4
) (
    input  logic            clk,
    input  logic            rst,
    slave_bus_if.slave      bus,
    input  logic [NPIN-1:0] pin_in,
    output logic [NPIN-1:0] pin_val,
    output logic            irq
);

    logic [7:0]      pre_cnt, div_q;
    logic            tick;
    logic [NPIN-1:0] rise, fall;
    logic [NPIN-1:0] rise_en, fall_en, pending, irq_en;
    logic [NPIN-1:0] w1c_mask, pending_nxt;
    logic [7:0]      off;
    logic            wr;
    logic [BUS_DATA_W-1:0] rdata_c;
    logic            unused_bits;

    assign off = bus.addr[7:0];
    assign wr  = bus.ss && (bus.ttype == WRITE);
    assign unused_bits = ^{bus.addr[BUS_ADDR_W-1:8], bus.wdata};

    assign tick = (pre_cnt == div_q);

    for (genvar i = 0; i < NPIN; i++) begin : g_pin
        gpio_debounce #(.DB_TICKS(DB_TICKS)) u_db (
            .clk     (clk),
            .rst     (rst),
            .pin_in  (pin_in[i]),
            .tick    (tick),
            .pin_val (pin_val[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    // New edges are OR'd in after the clear so a same-cycle set survives W1C.
    assign w1c_mask    = (wr && off == GPIO_IRQ_PENDING) ? bus.wdata[NPIN-1:0] : '0;
    assign pending_nxt = (pending & ~w1c_mask) | (rise & rise_en) | (fall & fall_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            div_q   <= GPIO_IRQ_DIV_RST;
            rise_en <= '0;
            fall_en <= '0;
            pending <= '0;
            irq_en  <= '0;
        end else begin
            pending <= pending_nxt;
            if (wr && off == GPIO_IRQ_RISE_EN) rise_en <= bus.wdata[NPIN-1:0];
            if (wr && off == GPIO_IRQ_FALL_EN) fall_en <= bus.wdata[NPIN-1:0];
            if (wr && off == GPIO_IRQ_IRQ_EN)  irq_en  <= bus.wdata[NPIN-1:0];
            if (wr && off == GPIO_IRQ_DIV) begin
                div_q   <= bus.wdata[7:0];
                pre_cnt <= '0;
            end else if (tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        rdata_c = '0;
        case (off)
            GPIO_IRQ_PIN_VAL: rdata_c[NPIN-1:0] = pin_val;
            GPIO_IRQ_RISE_EN: rdata_c[NPIN-1:0] = rise_en;
            GPIO_IRQ_FALL_EN: rdata_c[NPIN-1:0] = fall_en;
            GPIO_IRQ_PENDING: rdata_c[NPIN-1:0] = pending;
            GPIO_IRQ_IRQ_EN:  rdata_c[NPIN-1:0] = irq_en;
            GPIO_IRQ_DIV:     rdata_c[7:0]      = div_q;
            default:          rdata_c           = '0;
        endcase
    end

    assign bus.rdata = rdata_c;
    assign bus.bdone = 1'b1;
    assign irq       = |(pending & irq_en);

endmodule
